dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder: the memory side of the datapath load/store interface.
//   Accepts one word request at a time, where the address is the datapath aluout and the write data is its writedata.
//   Inserts LATENCY wait states before returning readdata.
//   Drives stall so the datapath and PC hold while an access is outstanding.
//   Flags misaligned or out-of-range addresses instead of accessing the array.
// PARAMETERS
//   n        32  data/address width in bits
//   DEPTH    64  number of n-bit words in the array (power of 2); byte range 0..DEPTH*4-1
//   LATENCY  2   wait-state cycles between accept and response (0 allowed)
// PORTS
//   clk         input   1  clock, rising edge
//   rst         input   1  asynchronous, active-low reset
//   req_valid   input   1  request present (memread|memwrite from control)
//   req_we      input   1  1 = store, 0 = load
//   req_addr    input   n  byte address (aluout)
//   req_wdata   input   n  store data (writedata)
//   req_ready   output  1  responder can accept a request this cycle
//   resp_valid  output  1  one-cycle pulse: response valid
//   resp_rdata  output  n  load data (readdata); 0 for stores and errors
//   addr_err    output  1  qualifies resp_valid: request was misaligned or out of range
//   stall       output  1  hold datapath/PC this cycle
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, wait counter=0.
//   - req_ready=1; resp_valid=0; resp_rdata=0; addr_err=0; stall=0.
//   - Array contents are not cleared.
// - FSM states: IDLE, WAIT, RESP.
//   - IDLE: req_ready=1. req_valid=1 accepts the request. Go to WAIT if LATENCY>0, else RESP.
//   - WAIT: counter runs 1..LATENCY. Go to RESP when counter==LATENCY.
//   - RESP: resp_valid=1 for exactly one cycle, then IDLE unconditionally.
// - Accept latches req_we/req_addr/req_wdata.
//   - Input changes after accept are ignored until the next IDLE.
// - Latency: request accepted at edge T -> resp_valid high in cycle T+LATENCY+1.
//   - Next request is accepted no earlier than the cycle after RESP.
//   - Max throughput: one request per LATENCY+2 cycles.
// - stall (combinational) = (state==IDLE & req_valid) | (state==WAIT).
//   - stall is 0 in RESP, so the datapath advances on the response edge.
// - Address check at accept:
//   - err = (addr[1:0]!=0) | (addr >= DEPTH*4).
//   - Word index = addr[$clog2(DEPTH)+1:2].
// - Load: resp_rdata = mem[index] during RESP. After RESP, resp_rdata holds its last value.
// - Store: mem[index] <= wdata on the edge entering RESP. resp_rdata=0 in RESP.
// - Error: no array read or write. In RESP: addr_err=1, resp_rdata=0. Error response uses the same latency.
// - addr_err is 0 whenever resp_valid is 0.
// - Reset during WAIT or RESP:
//   - Aborts the access, returns to IDLE, and no response is produced.
//   - A store aborted in WAIT is not committed.
// - Counter width: $clog2(LATENCY+1), minimum 1. No wrap: the counter is cleared on leaving WAIT.
// TESTING (n=32, DEPTH=64, LATENCY=2 unless noted)
// 1. Hold rst=0, then release -> req_ready=1, resp_valid=0, resp_rdata=0, stall=0, addr_err=0.
// 2. Store 0xABCD1234 @0x10 accepted at cycle 0 -> stall=1 in cycles 0..2, resp_valid=1 in cycle 3.
//    Then load @0x10 -> resp_rdata=0xABCD1234 in cycle 3 after its accept.
// 3. Load @0x06 -> addr_err=1, resp_rdata=0.
//    Store 0xFFFFFFFF @0x100 -> addr_err=1; a later load @0x00 returns its prior value.
// 4. Load @0x10 accepted, then req_addr changed to 0x14 during WAIT -> response returns mem[0x10].
// 5. Store 0x5 @0x20 over prior value 0x7; pulse rst=0 in WAIT -> no resp_valid. Load @0x20 returns 0x7.
// 6. LATENCY=0 instance: load accepted at cycle 0 -> resp_valid in cycle 1.
//    Back-to-back loads -> second accepted in cycle 2.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the datapath load/store port: one word access at a time,
// LATENCY wait states, stall generation and misaligned/out-of-range flagging.
module dmem_responder #(
    parameter int n       = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [n-1:0] resp_rdata,
    output logic         addr_err,
    output logic         stall
);

    localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;

    // Request captured at accept; later input changes are ignored.
    logic          we_q;
    logic          err_q;
    logic [IW-1:0] idx_q;
    logic [n-1:0]  wdata_q;

    logic          req_ready_q;
    logic          resp_valid_q;
    logic          addr_err_q;
    logic [n-1:0]  resp_rdata_q;

    logic [n-1:0]  mem [DEPTH];

    logic          in_err;
    logic [IW-1:0] in_idx;
    logic          accept;
    logic          wait_done;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [n-1:0]  mem_wdata;

    // Byte addresses at or above DEPTH*4 have a set bit above the word index.
    assign in_err    = (req_addr[1:0] != 2'b00) | (|req_addr[n-1:IW+2]);
    assign in_idx    = req_addr[IW+1:2];

    assign accept    = (state_q == IDLE) && req_valid;
    assign wait_done = (state_q == WAIT) && (cnt_q == LAST);

    // A zero-latency store commits on its accept edge, straight from the inputs.
    assign mem_we    = (state_q == IDLE) ? (accept && (LATENCY == 0) && req_we && !in_err)
                                         : (wait_done && we_q && !err_q);
    assign mem_idx   = (state_q == IDLE) ? in_idx : idx_q;
    assign mem_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign stall      = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign addr_err   = addr_err_q;

    // NOTE: the array has no reset; clearing it would turn it into flops and a reset tree.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        err_q       <= in_err;
                        idx_q       <= in_idx;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            addr_err_q   <= in_err;
                            resp_rdata_q <= (req_we || in_err) ? '0 : mem[in_idx];
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == LAST) begin
                        state_q      <= RESP;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        addr_err_q   <= err_q;
                        resp_rdata_q <= (we_q || err_q) ? '0 : mem[idx_q];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // Read data is left in place after the pulse.
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    addr_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    resp_valid_q <= 1'b0;
                    addr_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance
// share the clock and reset; monitors pop expected responses as resp_valid pulses.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        req_valid, req_we, req_ready, resp_valid, addr_err, stall;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        v0, we0, rdy0, rv0, err0, st0;
    logic [31:0] a0, wd0, rd0;

    exp_t exp_q[$];
    exp_t exp0_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .addr_err   (addr_err),
        .stall      (stall)
    );

    dmem_responder #(.n(32), .DEPTH(64), .LATENCY(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (v0),
        .req_we     (we0),
        .req_addr   (a0),
        .req_wdata  (wd0),
        .req_ready  (rdy0),
        .resp_valid (rv0),
        .resp_rdata (rd0),
        .addr_err   (err0),
        .stall      (st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor for the LATENCY=2 instance.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", resp_rdata, addr_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", 32'(addr_err), 32'(e.err));
                end
            end else begin
                check("err_without_valid", 32'(addr_err), 32'd0);
            end
        end
    end

    // Monitor for the LATENCY=0 instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && rv0 === 1'b1) begin
            if (exp0_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp0: got rdata %h err %b, expected no response", rd0, err0);
            end else begin
                exp_t e;
                e = exp0_q.pop_front();
                check("resp0_rdata", rd0, e.rdata);
                check("resp0_err", 32'(err0), 32'(e.err));
            end
        end
    end

    // One full transaction on the LATENCY=2 instance; optionally scrambles inputs during WAIT.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input bit scramble);
        int k;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back('{exp_rdata, exp_err});
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (scramble) begin
            req_addr  = 32'h14;
            req_we    = 1'b1;
            req_wdata = 32'hDEAD_BEEF;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (resp_valid !== 1'b1 && k < 20);
        check("latency", 32'(k), 32'd3);
        @(posedge clk);
    endtask

    initial begin
        int seen;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst0_ready", 32'(rdy0), 32'd1);

        // Store 0xABCD1234 @0x10 with cycle-exact stall/valid checks
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hABCD_1234;
        exp_q.push_back('{32'h0, 1'b0});
        @(negedge clk);
        check("c0_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("c1_stall", 32'(stall), 32'd1);
        check("c1_valid", 32'(resp_valid), 32'd0);
        check("c1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("c2_stall", 32'(stall), 32'd1);
        check("c2_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("c3_valid", 32'(resp_valid), 32'd1);
        check("c3_stall", 32'(stall), 32'd0);
        @(posedge clk);

        do_req(1'b0, 32'h10, 32'h0, 32'hABCD_1234, 1'b0, 1'b0);
        @(negedge clk);
        check("rdata_hold", resp_rdata, 32'hABCD_1234);

        // Address errors and boundaries
        do_req(1'b1, 32'h00, 32'h1111_1111, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b1, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, 32'h00, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
        do_req(1'b1, 32'hFC, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'hFC, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b0);

        // Inputs changed during WAIT are ignored
        do_req(1'b1, 32'h14, 32'h1414_1414, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 32'hABCD_1234, 1'b0, 1'b1);
        do_req(1'b0, 32'h14, 32'h0, 32'h1414_1414, 1'b0, 1'b0);

        // Reset during WAIT aborts a store
        do_req(1'b1, 32'h20, 32'h7, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 32'h20, 32'h0, 32'h7, 1'b0, 1'b0);

        // LATENCY=0 instance
        @(posedge clk);
        #1;
        v0 = 1'b1; we0 = 1'b1; a0 = 32'h8; wd0 = 32'hCAFE_F00D;
        exp0_q.push_back('{32'h0, 1'b0});
        @(negedge clk);
        check("l0_stall_c0", 32'(st0), 32'd1);
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        check("l0_valid_c1", 32'(rv0), 32'd1);
        check("l0_stall_c1", 32'(st0), 32'd0);
        @(posedge clk);

        #1;
        v0 = 1'b1; we0 = 1'b0; a0 = 32'h8;
        exp0_q.push_back('{32'hCAFE_F00D, 1'b0});
        exp0_q.push_back('{32'hCAFE_F00D, 1'b0});
        @(negedge clk);
        check("b2b_ready_c0", 32'(rdy0), 32'd1);
        @(negedge clk);
        check("b2b_valid_c1", 32'(rv0), 32'd1);
        check("b2b_ready_c1", 32'(rdy0), 32'd0);
        @(negedge clk);
        check("b2b_ready_c2", 32'(rdy0), 32'd1);
        check("b2b_stall_c2", 32'(st0), 32'd1);
        check("b2b_valid_c2", 32'(rv0), 32'd0);
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        check("b2b_valid_c3", 32'(rv0), 32'd1);

        @(posedge clk);
        #1;
        v0 = 1'b1; we0 = 1'b0; a0 = 32'h2;
        exp0_q.push_back('{32'h0, 1'b1});
        @(posedge clk);
        #1 v0 = 1'b0;

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("scoreboard0_empty", 32'(exp0_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
